// File: rtl/interp_upsampler.sv
`default_nettype none
// ============================================================================
// Module   : interp_upsampler
// Purpose  : Rate-R upsampler placed in front of the FIR interpolation stage.
//            Each accepted input sample becomes R output samples: the sample
//            itself (phase 0) followed by R-1 zeros. R is programmable at
//            runtime and is latched together with each accepted sample.
//            Under continuous flow the block produces one output per cycle
//            with no bubble between frames.
// Optional : define INTERP_UPSAMPLER_HOLD_EN to add a hold_mode input.
//            hold_mode=1 repeats the sample on phases 1..R-1 (zero-order hold).
//            hold_mode=0 uses zero stuffing.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            hold_mode  (HOLD_EN builds only) zero-order hold select
//            ratio      upsampling factor R, sampled on input acceptance
//            in_valid   input sample valid
//            in_ready   input can be accepted this cycle
//            in_data    signed input sample
//            out_valid  output sample valid
//            out_ready  downstream accepts output this cycle
//            out_data   signed output sample
//            out_first  out_data is the phase-0 (real) sample
//            busy       a frame is in progress
//            ratio_err  one-cycle pulse after a ratio of 0 was latched
// Revision : 1.0 - initial release
// ============================================================================
module interp_upsampler #(
  parameter int DATA_W  = 32,
  parameter int RATIO_W = 8
) (
  input  logic               clk,
  input  logic               rst,
`ifdef INTERP_UPSAMPLER_HOLD_EN
  input  logic               hold_mode,
`endif
  input  logic [RATIO_W-1:0] ratio,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_first,
  output logic               busy,
  output logic               ratio_err
);

  localparam logic [RATIO_W-1:0] c_ratio_one = {{(RATIO_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t             r_state;
  logic [RATIO_W-1:0] r_ratio;
  logic [RATIO_W-1:0] r_phase;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_first;
  logic               r_err;

  logic               w_emit;
  logic               w_last;
  logic               w_accept;
  logic               w_xfer;
  logic               w_ratio_zero;
  logic [RATIO_W-1:0] w_ratio_eff;
  logic [DATA_W-1:0]  w_fill;

  assign w_emit       = (r_state == ST_EMIT);
  // r_ratio is never 0, so r_ratio-1 cannot underflow and the phase counter
  // reaches at most 2^RATIO_W-2 without wrapping.
  assign w_last       = (r_phase == (r_ratio - c_ratio_one));
  assign w_ratio_zero = (ratio == '0);
  assign w_ratio_eff  = w_ratio_zero ? c_ratio_one : ratio;

  // Ready only when idle or on the final transfer of a frame, which lets the
  // next sample be taken in the same cycle with no bubble.
  assign in_ready = (r_state == ST_IDLE) | (w_emit & w_last & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_xfer   = w_emit & out_ready;

`ifdef INTERP_UPSAMPLER_HOLD_EN
  logic [DATA_W-1:0] r_data;
  logic              r_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_hold <= 1'b0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_hold <= hold_mode;
    end
  end

  assign w_fill = r_hold ? r_data : '0;
`else
  assign w_fill = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ratio     <= c_ratio_one;
      r_phase     <= '0;
      r_out_data  <= '0;
      r_out_first <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        // New frame: phase 0 presents the sample itself on the next cycle.
        r_state     <= ST_EMIT;
        r_ratio     <= w_ratio_eff;
        r_phase     <= '0;
        r_out_data  <= in_data;
        r_out_first <= 1'b1;
        r_err       <= w_ratio_zero;
      end else if (w_xfer) begin
        if (w_last) begin
          r_state     <= ST_IDLE;
          r_phase     <= '0;
          r_out_data  <= '0;
          r_out_first <= 1'b0;
        end else begin
          r_phase     <= r_phase + c_ratio_one;
          r_out_data  <= w_fill;
          r_out_first <= 1'b0;
        end
      end
    end
  end

  assign out_valid = w_emit;
  assign busy      = w_emit;
  assign out_data  = r_out_data;
  assign out_first = r_out_first;
  assign ratio_err = r_err;

endmodule
`default_nettype wire

// File: doc/interp_upsampler.md
Name: interp_upsampler

Overview:
Parametrised rate-R upsampler for the interpolation filter chain. Each accepted input sample is expanded into R output samples: the real sample followed by R-1 zeros. Valid/ready handshakes run on both sides. The ratio is runtime-programmable and latched per input sample. The block sits between the sample source and the FIR interpolation stage, and sustains full throughput (one output per cycle) under continuous flow.

Parameters:
DATA_W, 32, width of signed input/output samples
RATIO_W, 8, width of the runtime ratio port (R range 1..2^RATIO_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ratio  in  RATIO_W  upsampling factor R, sampled only on input acceptance
in_valid  in  1  input sample valid
in_ready  out  1  block can accept input this cycle
in_data  in  DATA_W  signed input sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output this cycle
out_data  out  DATA_W  signed output sample
out_first  out  1  high when out_data is the real (phase-0) sample
busy  out  1  high while a frame (R outputs) is in progress
ratio_err  out  1  one-cycle pulse when ratio==0 was latched

Behaviour:
- Reset: state IDLE, out_valid=0, out_data=0, out_first=0, busy=0, ratio_err=0, phase=0, held sample=0, latched R=1. Reset mid-frame discards remaining phases; nothing is emitted after reset until a new input is accepted.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch in_data, latch R=ratio (ratio==0 is coerced to R=1 and pulses ratio_err next cycle), set phase=0, go to EMIT.
- State EMIT:
  - out_valid=1, busy=1.
  - out_data = held sample when phase==0, else 0.
  - out_first = (phase==0).
- Output transfer: occurs when out_valid && out_ready. Outputs hold stable while out_ready=0 (no change to data/phase).
- On transfer with phase < R-1: phase increments.
- On transfer with phase == R-1 (last phase):
  - in_ready is combinationally high that cycle (in_ready = IDLE | (EMIT & last phase & out_ready)).
  - If in_valid: accept new sample and new ratio, phase=0, stay in EMIT (back-to-back, no bubble).
  - Else: go to IDLE; out_valid=0 and out_data=0 next cycle.
- Latency: first output (phase 0) is valid the cycle after input acceptance.
- Throughput:
  - 1 output/cycle while out_ready=1 and input is available.
  - Input rate is 1 per R cycles.
- R=1: passthrough with one-cycle latency; every output has out_first=1.
- Ratio changes while in EMIT are ignored until the next acceptance.
- Phase counter is RATIO_W bits. R=2^RATIO_W-1 must complete without wrap.
- Data passes unmodified; no gain compensation in this block.
- in_ready must never be high in EMIT except on the last-phase transfer cycle.

Optional Feature:
Macro INTERP_UPSAMPLER_HOLD_EN.
- Defined: adds input port hold_mode (1 bit), latched with each sample.
  - hold_mode=1: phases 1..R-1 output the held sample (zero-order hold) instead of zero.
  - hold_mode=0: zero stuffing as above.
  - out_first behaviour is unchanged.
- Not defined: port absent; always zero stuffing.

Test Plan:
1. Reset then idle: rst high 2 cycles, no in_valid -> out_valid=0, out_data=0, in_ready=1, busy=0.
2. ratio=3, continuous in_data 5,-7, out_ready=1 -> out_data sequence 5,0,0,-7,0,0; out_first 1,0,0,1,0,0; in_ready high only on the accept cycles; no bubbles.
3. ratio=4, sample 100, out_ready low for 2 cycles at phase 1 -> out_data holds 0 and phase holds; total 4 transfers; next sample accepted only on the 4th transfer.
4. ratio=0 with sample 9 -> ratio_err pulses once; single output 9 with out_first=1; then IDLE.
5. ratio changed 2->5 mid-frame of sample 1 -> sample 1 emits 2 outputs; next sample emits 5.
6. rst asserted at phase 2 of an R=8 frame -> next cycle out_valid=0, busy=0, in_ready=1; with HOLD_EN and hold_mode=1, R=3, sample 42 -> outputs 42,42,42.
